// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg -- shared definitions for the iterative multiply/divide unit.
//
// Contents:
//   md_op_e      operation encodings (MULTU, MULT, DIVU, DIV)
//   md_state_e   sequencer state encoding (IDLE, CALC, FIX)
//   MD_WIDTH     default operand width
//   MD_CNT_W     iteration counter width for the default operand width
//   md_cnt_width counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package md_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = $clog2(MD_WIDTH) + 1;

  // Bit 1 selects divide, bit 0 selects signed.
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int unsigned md_cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage : md_pkg

// File: rtl/md_step.sv
// -----------------------------------------------------------------------------
// md_step -- one combinational iteration of the shift-based MD datapath.
//
// Multiply (is_div_i = 0): shift-and-add, LSB-first on the multiplier.
//   {acc, q} is the 2*WIDTH accumulator; q starts as the multiplier and
//   fills with product bits from the top as the multiplier shifts out.
// Divide (is_div_i = 1): restoring divide.
//   {acc, q} is {remainder, quotient}; q starts as the dividend.
//
// Ports:
//   is_div_i  1      step type: 0 multiply, 1 divide
//   acc_i     WIDTH  accumulator high half / partial remainder
//   q_i       WIDTH  multiplier-product low half / dividend-quotient
//   opnd_i    WIDTH  multiplicand or divisor (magnitude)
//   acc_o     WIDTH  next accumulator / remainder
//   q_o       WIDTH  next multiplier / quotient
// -----------------------------------------------------------------------------
module md_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    acc_o  = acc_i;
    q_o    = q_i;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;

    if (is_div_i) begin
      // Shifted remainder needs WIDTH+1 bits: it can reach 2*divisor-1.
      rem_sh = {acc_i, q_i[WIDTH-1]};
      diff   = rem_sh - {1'b0, opnd_i};
      // Top bit of diff is the borrow: clear means the trial subtract fits.
      if (!diff[WIDTH]) begin
        acc_o = diff[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = rem_sh[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc_i} + (q_i[0] ? {1'b0, opnd_i} : '0);
      // Shift {carry, sum, q} right by one; the sum LSB becomes a product bit.
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule : md_step

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit -- iterative multiply/divide unit owning the HI/LO registers.
//
// Executes MULTU/MULT/DIVU/DIV over WIDTH datapath iterations (IDLE -> CALC
// -> FIX -> IDLE) and services MTHI/MTLO writes while idle.
//
// Ports:
//   clk      1      rising-edge clock
//   reset    1      asynchronous active-low reset
//   start    1      launch an operation (sampled only in IDLE)
//   op       2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_data  WIDTH  multiplicand / dividend
//   rt_data  WIDTH  multiplier / divisor
//   hi_we    1      MTHI write enable (IDLE only)
//   lo_we    1      MTLO write enable (IDLE only)
//   wdata    WIDTH  MTHI/MTLO data
//   busy     1      state is not IDLE
//   done     1      one-cycle pulse after HI/LO are updated by an operation
//   hi, lo   WIDTH  HI/LO registers
// -----------------------------------------------------------------------------
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned    CW       = md_cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  md_state_e        state_q;
  md_op_e           op_q;
  logic [WIDTH-1:0] acc_q;    // product high half / remainder
  logic [WIDTH-1:0] quo_q;    // multiplier-product low half / quotient
  logic [WIDTH-1:0] opnd_q;   // multiplicand / divisor magnitude
  logic             sq_q;     // result (product/quotient) is negative
  logic             sr_q;     // remainder is negative
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] quo_d;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_q[1]),
    .acc_i    (acc_q),
    .q_i      (quo_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d),
    .q_o      (quo_d)
  );

  // Operand magnitudes and signs at launch; unsigned ops never negate.
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  assign rs_neg = op[0] & rs_data[WIDTH-1];
  assign rt_neg = op[0] & rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;

  // Sign correction applied in FIX.
  // Signed overflow (most-negative / -1) needs no special case: the
  // magnitudes give quotient 0x80..0, remainder 0, and negating 0x80..0
  // leaves it unchanged.
  logic                 div_by_zero;
  logic [2*WIDTH-1:0]   prod_raw;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign div_by_zero = (opnd_q == '0);
  assign prod_raw    = {acc_q, quo_q};
  assign prod_fix    = (op_q[0] & sq_q) ? -prod_raw : prod_raw;
  assign quo_fix     = (op_q[0] & sq_q) ? -quo_q : quo_q;
  // With a zero divisor every trial subtract succeeds, so the remainder ends
  // as the dividend magnitude; re-applying its sign restores the latched
  // rs_data exactly, which is the required HI for divide-by-zero.
  assign rem_fix     = (op_q[0] & sr_q) ? -acc_q : acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULTU;
      acc_q   <= '0;
      quo_q   <= '0;
      opnd_q  <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order in this block.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q    <= md_op_e'(op);
            sq_q    <= rs_neg ^ rt_neg;
            sr_q    <= rs_neg;
            acc_q   <= '0;
            // Divide shifts the dividend through quo; multiply shifts the
            // multiplier through it.
            quo_q   <= op[1] ? rs_mag : rt_mag;
            opnd_q  <= op[1] ? rt_mag : rs_mag;
            cnt_q   <= '0;
            state_q <= S_CALC;
          end
        end

        S_CALC: begin
          acc_q <= acc_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end

        S_FIX: begin
          if (op_q[1]) begin
            hi_q <= rem_fix;
            lo_q <= div_by_zero ? '1 : quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : mult_div_unit

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit -- self-checking bench for mult_div_unit (WIDTH = 32).
// Directed cases followed by 1000 random back-to-back operations compared
// against a 64-bit arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;
  int exp_done  = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every done pulse observed, to catch lost or duplicated completions.
  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: begin
        p = sa * sb;
        return p;
      end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;   // truncates toward zero
        r = sa % sb;   // takes the dividend's sign
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called at a negedge: start is sampled at the following posedge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles on the way.
  task automatic wait_done(output int nbusy);
    int n = 0;
    nbusy = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) nbusy++;
      n++;
      @(negedge clk);
    end
    check("done_seen", 64'(done), 64'd1);
    exp_done++;
  endtask

  initial begin
    int nb;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] exp_hl;

    reset   = 1'b0;
    start   = 1'b0;
    op      = 2'd0;
    rs_data = '0;
    rt_data = '0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    wdata   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    reset = 1'b1;
    @(negedge clk);

    // MULTU max*max; busy spans WIDTH+1 cycles (WIDTH+2 with the start cycle)
    launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb);
    check("multu_busy_cycles", 64'(nb), 64'(W + 1));
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);
    check("multu_busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("multu_done_single", 64'(done), 64'd0);

    // MULT -3 * 7
    launch(2'd1, 32'hFFFF_FFFD, 32'd7);
    wait_done(nb);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    // DIV -7 / 2 (issued in the done cycle)
    launch(2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(nb);
    check("div_busy_cycles", 64'(nb), 64'(W + 1));
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    // DIVU by zero
    launch(2'd2, 32'd100, 32'd0);
    wait_done(nb);
    check("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("divu0_hi", 64'(hi), 64'd100);

    // Signed DIV by zero returns the raw dividend in HI
    launch(2'd3, 32'hFFFF_FFF0, 32'd0);
    wait_done(nb);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("div0_hi", 64'(hi), 64'hFFFF_FFF0);

    // Signed overflow
    launch(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(nb);
    check("divovf_lo", 64'(lo), 64'h8000_0000);
    check("divovf_hi", 64'(hi), 64'd0);

    // MTLO in IDLE
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_hi_kept", 64'(hi), 64'd0);

    // MTHI while busy is dropped; result arrives normally
    launch(2'd2, 32'd50, 32'd7);
    repeat (3) @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_busy_dropped", 64'(hi), 64'd0);
    wait_done(nb);
    check("mthi_res_hi", 64'(hi), 64'd1);
    check("mthi_res_lo", 64'(lo), 64'd7);

    // Second start mid-operation is ignored
    launch(2'd0, 32'd3, 32'd5);
    repeat (8) @(negedge clk);
    op      = 2'd2;
    rs_data = 32'd1;
    rt_data = 32'd1;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done(nb);
    check("ign_hi", 64'(hi), 64'd0);
    check("ign_lo", 64'(lo), 64'd15);
    repeat (40) @(negedge clk);
    check("ign_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a DIVU
    launch(2'd2, 32'hDEAD_BEEF, 32'd3);
    repeat (14) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi",   64'(hi),   64'd0);
    check("arst_lo",   64'(lo),   64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    launch(2'd2, 32'd1000, 32'd7);
    wait_done(nb);
    check("post_rst_busy_cycles", 64'(nb), 64'(W + 1));
    check("post_rst_lo", 64'(lo), 64'd142);
    check("post_rst_hi", 64'(hi), 64'd6);

    // Random back-to-back operations, each issued in the previous done cycle
    for (int i = 0; i < 1000; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ro = 2'd3; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      exp_hl = ref_md(ro, ra, rb);
      launch(ro, ra, rb);
      wait_done(nb);
      check($sformatf("rnd%0d_op%0d_hi", i, ro), 64'(hi), 64'(exp_hl[63:32]));
      check($sformatf("rnd%0d_op%0d_lo", i, ro), 64'(lo), 64'(exp_hl[31:0]));
      check($sformatf("rnd%0d_busy_cycles", i), 64'(nb), 64'(W + 1));
    end

    repeat (5) @(negedge clk);
    #1;
    check("done_pulse_total", 64'(done_seen), 64'(exp_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mult_div_unit
